vga_sync_gen: RTL and testbench

//  - Raster timing generator for the image-memory display path; sits directly upstream of the image ROM stage.
//  - Divides the system clock into a pixel-rate tick and runs horizontal/vertical counters.
//  - Drives pixel_x/pixel_y to the ROM stage and hsync/vsync/video_on to the VGA pins.
//  - Sync/video_on are delayable by PIPE_DLY ticks so they align with the ROM's registered read data.

---
 rtl/vga_sync_gen_pkg.sv | 27 ++
 rtl/vga_sync_gen_tick.sv | 37 +++
 rtl/vga_sync_gen.sv | 123 ++++++++++++
 tb/tb_vga_sync_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 raster defaults, counter type and sync-flag bundle for the
// VGA timing path; the image-memory stage imports the same package.
package vga_sync_gen_pkg;
  localparam int VGA_CNT_W     = 10;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_PIPE_MAX  = 4;

  typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

  typedef struct packed {
    logic vid;
    logic hs;
    logic vs;
  } vga_flags_t;

  // True when lo <= c < hi.
  function automatic logic in_window(input vga_cnt_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction
endpackage

// File: rtl/vga_sync_gen_tick.sv
// Pixel-rate tick divider: one registered pulse every CLK_DIV enabled clocks.
// With en low the divider holds and the tick output is masked.
module vga_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  always_comb begin
    div_d  = div_q;
    tick_d = tick_q;
    if (en_i) begin
      tick_d = (div_q == DIV_LAST);
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q & en_i;
endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: h/v counters on the pixel tick, registered flag
// decode, and a tick-clocked delay line aligning sync/video_on with ROM data.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter bit SYNC_POL  = 1'b0,
  parameter int PIPE_DLY  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 pixel_tick,
  output logic [VGA_CNT_W-1:0] pixel_x,
  output logic [VGA_CNT_W-1:0] pixel_y,
  output logic                 video_on,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 line_start,
  output logic                 frame_start
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam vga_cnt_t H_LAST = vga_cnt_t'(H_TOTAL - 1);
  localparam vga_cnt_t V_LAST = vga_cnt_t'(V_TOTAL - 1);

  if (CLK_DIV < 1) begin : gen_bad_div
    $error("vga_sync_gen: CLK_DIV must be at least 1");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > VGA_PIPE_MAX) begin : gen_bad_dly
    $error("vga_sync_gen: PIPE_DLY out of range 0..4");
  end
  if (H_TOTAL > (1 << VGA_CNT_W) || V_TOTAL > (1 << VGA_CNT_W)) begin : gen_bad_total
    $error("vga_sync_gen: raster totals exceed counter width");
  end

  logic tick;

  vga_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (en),
    .tick_o (tick)
  );

  vga_cnt_t   h_q, h_d, v_q, v_d;
  vga_flags_t raw_q, raw_d;
  logic       ls_q, ls_d, fs_q, fs_d;

  // Flags are decoded from the next counts so they land with pixel_x/pixel_y.
  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    raw_d = raw_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (tick) begin
      h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
      if (h_q == H_LAST) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
      raw_d.vid = (int'(h_d) < H_DISPLAY) && (int'(v_d) < V_DISPLAY);
      raw_d.hs  = in_window(h_d, H_DISPLAY + H_FRONT, H_DISPLAY + H_FRONT + H_SYNC);
      raw_d.vs  = in_window(v_d, V_DISPLAY + V_FRONT, V_DISPLAY + V_FRONT + V_SYNC);
      ls_d      = (h_q == H_LAST);
      fs_d      = (h_q == H_LAST) && (v_q == V_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q   <= '0;
      v_q   <= '0;
      raw_q <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      raw_q <= raw_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  vga_flags_t out_f;

  if (PIPE_DLY == 0) begin : gen_nodly
    assign out_f = raw_q;
  end else begin : gen_dly
    vga_flags_t [PIPE_DLY-1:0] dly_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dly_q <= '0;
      end else if (tick) begin
        dly_q[0] <= raw_q;
        for (int i = 1; i < PIPE_DLY; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign out_f = dly_q[PIPE_DLY-1];
  end

  assign pixel_tick  = tick;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign video_on    = out_f.vid;
  assign hsync       = out_f.hs ? SYNC_POL : ~SYNC_POL;
  assign vsync       = out_f.vs ? SYNC_POL : ~SYNC_POL;
  assign line_start  = ls_q & en;
  assign frame_start = fs_q & en;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three small-raster instances (divide 4 / delay 0,
// divide 4 / delay 2, divide 1 / delay 1 high-polarity) against a tick-count model.
module tb_vga_sync_gen;
  localparam int HD = 16, HF = 4, HS = 6, HB = 5;
  localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk, rst, en;

  logic       d0_tick, d0_vid, d0_hs, d0_vs, d0_ls, d0_fs;
  logic [9:0] d0_x, d0_y;
  logic       d2_tick, d2_vid, d2_hs, d2_vs, d2_ls, d2_fs;
  logic [9:0] d2_x, d2_y;
  logic       c1_tick, c1_vid, c1_hs, c1_vs, c1_ls, c1_fs;
  logic [9:0] c1_x, c1_y;

  logic [25:0] obs_d0, obs_d2, obs_c1;
  assign obs_d0 = {d0_tick, d0_x, d0_y, d0_vid, d0_hs, d0_vs, d0_ls, d0_fs};
  assign obs_d2 = {d2_tick, d2_x, d2_y, d2_vid, d2_hs, d2_vs, d2_ls, d2_fs};
  assign obs_c1 = {c1_tick, c1_x, c1_y, c1_vid, c1_hs, c1_vs, c1_ls, c1_fs};

  vga_sync_gen #(.CLK_DIV(4), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0), .PIPE_DLY(0)) u_d0 (
    .clk(clk), .rst(rst), .en(en), .pixel_tick(d0_tick), .pixel_x(d0_x), .pixel_y(d0_y),
    .video_on(d0_vid), .hsync(d0_hs), .vsync(d0_vs), .line_start(d0_ls), .frame_start(d0_fs));

  vga_sync_gen #(.CLK_DIV(4), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0), .PIPE_DLY(2)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .pixel_tick(d2_tick), .pixel_x(d2_x), .pixel_y(d2_y),
    .video_on(d2_vid), .hsync(d2_hs), .vsync(d2_vs), .line_start(d2_ls), .frame_start(d2_fs));

  vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1), .PIPE_DLY(1)) u_c1 (
    .clk(clk), .rst(rst), .en(en), .pixel_tick(c1_tick), .pixel_x(c1_x), .pixel_y(c1_y),
    .video_on(c1_vid), .hsync(c1_hs), .vsync(c1_vs), .line_start(c1_ls), .frame_start(c1_fs));

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: m = enabled clocks since reset, t = ticks consumed.
  int  m_cnt [3];
  int  t_cnt [3];
  bit  cons  [3];
  logic [77:0] exp_q [$];

  function automatic int div_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic logic [25:0] model_out(input int k, input bit en_now);
    int d, p, t, x, y, j, jx, jy;
    bit pol, tk, ls, fs, vid, hs, vs;
    d   = div_of(k);
    p   = (k == 0) ? 0 : ((k == 1) ? 2 : 1);
    pol = (k == 2);
    t   = t_cnt[k];
    x   = t % HT;
    y   = (t / HT) % VT;
    tk  = en_now && (m_cnt[k] > 0) && (m_cnt[k] % d == 0);
    ls  = en_now && cons[k] && (x == 0);
    fs  = ls && (y == 0);
    vid = 1'b0;
    hs  = 1'b0;
    vs  = 1'b0;
    j   = t - p;
    if (j >= 1) begin
      jx  = j % HT;
      jy  = (j / HT) % VT;
      vid = (jx < HD) && (jy < VD);
      hs  = (jx >= HD + HF) && (jx < HD + HF + HS);
      vs  = (jy >= VD + VF) && (jy < VD + VF + VS);
    end
    return {tk, x[9:0], y[9:0], vid, hs ? pol : ~pol, vs ? pol : ~pol, ls, fs};
  endfunction

  initial begin : ref_model
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst) begin
          m_cnt[k] = 0;
          t_cnt[k] = 0;
          cons[k]  = 1'b0;
        end else begin
          cons[k] = en && (m_cnt[k] > 0) && (m_cnt[k] % div_of(k) == 0);
          if (cons[k]) t_cnt[k]++;
          if (en) m_cnt[k]++;
        end
      end
      exp_q.push_back({model_out(0, en), model_out(1, en), model_out(2, en)});
    end
  end

  // Scoreboard
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [77:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL exp_queue observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      check("stream_div4_dly0", 32'(obs_d0), 32'(e[77:52]));
      check("stream_div4_dly2", 32'(obs_d2), 32'(e[51:26]));
      check("stream_div1_dly1", 32'(obs_c1), 32'(e[25:0]));
    end
  endtask

  int n, n0, nc, vid0, hs0, vs2, vid2, ls0;
  bit found, found2;

  initial begin : stim
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) step();
    check("rst_pixel_x", 32'(d2_x), 0);
    check("rst_pixel_y", 32'(d2_y), 0);
    check("rst_video_on", 32'(d0_vid), 0);
    check("rst_hsync_lowpol", 32'(d2_hs), 1);
    check("rst_vsync_highpol", 32'(c1_vs), 0);
    check("rst_tick_div1", 32'(c1_tick), 0);

    // Release: first tick after CLK_DIV clocks, pixel_x = 1 one clock later.
    rst   = 1'b1;
    found = 1'b0;
    n     = 0;
    for (int i = 1; i <= 16 && !found; i++) begin
      step();
      if (d2_tick) begin
        found = 1'b1;
        n     = i;
      end
    end
    check("first_tick_clks", n, 4);
    step();
    check("first_pixel_x", 32'(d2_x), 1);

    // One full frame with en held high.
    found = 1'b0;
    for (int i = 0; i < 2 * FT * 4 + 8 && !found; i++) begin
      step();
      found = d0_fs;
    end
    check("frame_start_seen", 32'(found), 1);
    n = 0; vid0 = 0; hs0 = 0; vs2 = 0; vid2 = 0; ls0 = 0;
    found = 1'b0;
    while (!found && n < 2 * FT * 4) begin
      if (d0_tick && d0_vid) vid0++;
      if (d0_tick && !d0_hs) hs0++;
      if (d2_tick && !d2_vs) vs2++;
      if (d2_tick && d2_vid) vid2++;
      if (d0_ls) ls0++;
      step();
      n++;
      found = d0_fs;
    end
    check("frame_period_clks", n, FT * 4);
    check("video_ticks_dly0", vid0, HD * VD);
    check("video_ticks_dly2", vid2, HD * VD);
    check("hsync_low_ticks", hs0, HS * VT);
    check("vsync_low_ticks", vs2, VS * HT);
    check("line_starts_per_frame", ls0, VT);

    // Random enable gaps.
    for (int i = 0; i < 2500; i++) begin
      step();
      en = ($urandom_range(0, 9) != 0);
    end
    en = 1'b1;

    // Freeze for 37 clocks right after pixel_x becomes 20.
    found  = 1'b0;
    found2 = 1'b0;
    for (int i = 0; i < HT * 4 * 3 && !found; i++) begin
      step();
      found = (d2_x == 10'd19);
    end
    for (int i = 0; i < 8 && !found2; i++) begin
      step();
      found2 = (d2_x == 10'd20);
    end
    check("freeze_reach_x20", 32'(found && found2), 1);
    en = 1'b0;
    n  = 0;
    repeat (37) begin
      step();
      if (d0_tick || d2_tick || c1_tick) n++;
    end
    check("freeze_no_tick", n, 0);
    check("freeze_pixel_x", 32'(d2_x), 20);
    en    = 1'b1;
    found = 1'b0;
    n     = 0;
    for (int i = 1; i <= 12 && !found; i++) begin
      step();
      if (d2_x == 10'd21) begin
        found = 1'b1;
        n     = i;
      end
    end
    check("resume_pixel_x_clks", n, 4);

    // Asynchronous reset mid-frame at (25, 10).
    found = 1'b0;
    for (int i = 0; i < FT * 4 * 2 && !found; i++) begin
      step();
      found = (d2_y == 10'd10) && (d2_x == 10'd25);
    end
    check("mid_frame_reached", 32'(found), 1);
    rst = 1'b0;
    #1;
    check("async_rst_x", 32'(d2_x), 0);
    check("async_rst_y", 32'(d2_y), 0);
    check("async_rst_hsync", 32'(d2_hs), 1);
    check("async_rst_vsync", 32'(d0_vs), 1);
    check("async_rst_hsync_highpol", 32'(c1_hs), 0);
    check("async_rst_video_on", 32'(c1_vid), 0);
    check("async_rst_tick", 32'(c1_tick), 0);
    repeat (2) step();
    rst = 1'b1;
    n0  = 0;
    nc  = 0;
    for (int i = 1; i <= FT * 4 + 40 && n0 == 0; i++) begin
      step();
      if (c1_fs && nc == 0) nc = i;
      if (d0_fs) n0 = i;
    end
    check("post_rst_frame_start_div1", nc, FT + 1);
    check("post_rst_frame_start_div4", n0, FT * 4 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
